// File: rtl/tsu_axis_stamp_if.sv
// 8-bit AXI-Stream link: master drives data/valid/last, slave returns ready.
interface tsu_axis_stamp_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/tsu_axis_stamp.sv
// Inline AXI-S time-stamping stage: stamps rtc+CORR at frame start, optionally appends it MSB first.
// Zero-latency pass-through, stalls follow m_axis.tready; frame counter present with TSU_FRAME_CNT_EN.
module tsu_axis_stamp #(
  parameter int          TS_W = 64,
  parameter int          MODE = 0,
  parameter logic [63:0] CORR = 64'd0
) (
  input  logic                   mac_axis_aclk,
  input  logic                   mac_axis_resetn,
  input  logic [63:0]            rtc_timer_in,
  tsu_axis_stamp_if.slave        s_axis,
  tsu_axis_stamp_if.master       m_axis,
  output logic [TS_W-1:0]        ts_out,
  output logic                   ts_valid
`ifdef TSU_FRAME_CNT_EN
  ,
  output logic [31:0]            frame_cnt
`endif
);

  localparam int         NB      = TS_W / 8;
  localparam logic [2:0] IDX_TOP = 3'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_APPEND} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_idx;
  logic [TS_W-1:0] r_stamp;
  logic            r_ts_vld;
  logic            w_s_hs;
  logic            w_m_hs;
  logic            w_cap;
  logic [7:0]      w_stamp_byte;
  logic [TS_W-1:0] w_stamp_new;
  logic            w_unused_rtc;

  assign w_stamp_new  = rtc_timer_in[TS_W-1:0] + CORR[TS_W-1:0];
  assign w_unused_rtc = ^rtc_timer_in;
  assign w_s_hs       = s_axis.tvalid & s_axis.tready;
  assign w_m_hs       = m_axis.tvalid & m_axis.tready;
  assign w_cap        = w_s_hs && (r_state == S_IDLE);

  always_comb begin
    w_stamp_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (r_idx == 3'(i)) begin
        w_stamp_byte = r_stamp[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge mac_axis_aclk or negedge mac_axis_resetn) begin
    if (!mac_axis_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = s_axis.tdata;
    m_axis.tlast  = 1'b0;
    case (r_state)
      S_IDLE, S_PASS: begin
        s_axis.tready = m_axis.tready;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tlast  = (MODE == 1) ? s_axis.tlast : 1'b0;
        if (s_axis.tvalid && m_axis.tready) begin
          if (!s_axis.tlast) begin
            w_state_nxt = S_PASS;
          end else if (MODE == 0) begin
            w_state_nxt = S_APPEND;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_APPEND: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = w_stamp_byte;
        m_axis.tlast  = (r_idx == 3'd0);
        if (m_axis.tready && (r_idx == 3'd0)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Outputs must go quiet the moment reset asserts, not at the next edge.
    if (!mac_axis_resetn) begin
      s_axis.tready = 1'b0;
      m_axis.tvalid = 1'b0;
      m_axis.tlast  = 1'b0;
    end
  end

  // r_stamp doubles as the sideband value: it is only reloaded at the next frame start.
  always_ff @(posedge mac_axis_aclk or negedge mac_axis_resetn) begin
    if (!mac_axis_resetn) begin
      r_idx    <= 3'd0;
      r_stamp  <= '0;
      r_ts_vld <= 1'b0;
    end else begin
      r_ts_vld <= w_cap;
      if (w_cap) begin
        r_stamp <= w_stamp_new;
      end
      if ((r_state != S_APPEND) && (w_state_nxt == S_APPEND)) begin
        r_idx <= IDX_TOP;
      end else if ((r_state == S_APPEND) && w_m_hs) begin
        r_idx <= (r_idx == 3'd0) ? IDX_TOP : r_idx - 3'd1;
      end
    end
  end

  assign ts_out   = r_stamp;
  assign ts_valid = r_ts_vld;

`ifdef TSU_FRAME_CNT_EN
  logic [31:0] r_frame_cnt;

  always_ff @(posedge mac_axis_aclk or negedge mac_axis_resetn) begin
    if (!mac_axis_resetn) begin
      r_frame_cnt <= 32'd0;
    end else if (w_m_hs && m_axis.tlast && (r_frame_cnt != 32'hFFFF_FFFF)) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_tsu_axis_stamp.sv
// Directed bench for tsu_axis_stamp: append mode (64/32-bit stamps), stall, sideband mode, reset mid-frame.
module tb_tsu_axis_stamp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rtc;

  always #5 clk = ~clk;

  tsu_axis_stamp_if s0 ();
  tsu_axis_stamp_if m0 ();
  tsu_axis_stamp_if s1 ();
  tsu_axis_stamp_if m1 ();
  tsu_axis_stamp_if s2 ();
  tsu_axis_stamp_if m2 ();

  logic [63:0] ts0;
  logic [31:0] ts1;
  logic [47:0] ts2;
  logic        tv0, tv1, tv2;
`ifdef TSU_FRAME_CNT_EN
  logic [31:0] fc0, fc1, fc2;
`endif

  int n_err = 0;
  int n_chk = 0;

  tsu_axis_stamp #(.TS_W(64), .MODE(0), .CORR(64'd0)) u0 (
    .mac_axis_aclk(clk), .mac_axis_resetn(rst_n), .rtc_timer_in(rtc),
    .s_axis(s0), .m_axis(m0), .ts_out(ts0), .ts_valid(tv0)
`ifdef TSU_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  tsu_axis_stamp #(.TS_W(32), .MODE(0), .CORR(64'd5)) u1 (
    .mac_axis_aclk(clk), .mac_axis_resetn(rst_n), .rtc_timer_in(rtc),
    .s_axis(s1), .m_axis(m1), .ts_out(ts1), .ts_valid(tv1)
`ifdef TSU_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  tsu_axis_stamp #(.TS_W(48), .MODE(1), .CORR(64'd0)) u2 (
    .mac_axis_aclk(clk), .mac_axis_resetn(rst_n), .rtc_timer_in(rtc),
    .s_axis(s2), .m_axis(m2), .ts_out(ts2), .ts_valid(tv2)
`ifdef TSU_FRAME_CNT_EN
    , .frame_cnt(fc2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] sb;
    logic [3:0]  rdy_pat;
    logic [7:0]  fb [6];
    logic [7:0]  e1 [4];
    int          k;
    int          cyc;

    rst_n = 1'b0;
    rtc   = 64'd0;
    s0.tvalid = 1'b0; s0.tdata = 8'h00; s0.tlast = 1'b0; m0.tready = 1'b1;
    s1.tvalid = 1'b0; s1.tdata = 8'h00; s1.tlast = 1'b0; m1.tready = 1'b1;
    s2.tvalid = 1'b0; s2.tdata = 8'h00; s2.tlast = 1'b0; m2.tready = 1'b1;

    // Reset state, with upstream valid held high to expose any pass-through leak
    @(negedge clk);
    s0.tvalid = 1'b1; s0.tdata = 8'h99; s0.tlast = 1'b1;
    #1;
    chk("rst_m_tvalid", m0.tvalid, 0);
    chk("rst_m_tlast",  m0.tlast,  0);
    chk("rst_s_tready", s0.tready, 0);
    chk("rst_ts_out",   ts0, 0);
    chk("rst_ts_valid", tv0, 0);
`ifdef TSU_FRAME_CNT_EN
    chk("rst_frame_cnt", fc0, 0);
`endif
    s0.tvalid = 1'b0; s0.tlast = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // 4-byte frame, 64-bit stamp appended MSB first
    s0.tvalid = 1'b1; s0.tdata = 8'h11; s0.tlast = 1'b0;
    rtc = 64'h0102030405060708;
    #1;
    chk("t1_b0_data",   m0.tdata,  8'h11);
    chk("t1_b0_vld",    m0.tvalid, 1);
    chk("t1_b0_last",   m0.tlast,  0);
    chk("t1_b0_srdy",   s0.tready, 1);
    step();
    rtc = 64'hFFFF_FFFF_FFFF_FFFF;
    s0.tdata = 8'h22;
    #1;
    chk("t1_ts_valid",  tv0, 1);
    chk("t1_ts_out",    ts0, 64'h0102030405060708);
    chk("t1_b1_data",   m0.tdata, 8'h22);
    step();
    s0.tdata = 8'h33;
    #1;
    chk("t1_ts_pulse_end", tv0, 0);
    chk("t1_b2_data",   m0.tdata, 8'h33);
    step();
    s0.tdata = 8'h44; s0.tlast = 1'b1;
    #1;
    chk("t1_b3_data",   m0.tdata, 8'h44);
    chk("t1_b3_last",   m0.tlast, 0);
    step();
    s0.tvalid = 1'b0; s0.tlast = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t1_app_data", m0.tdata,  64'(i + 1));
      chk("t1_app_vld",  m0.tvalid, 1);
      chk("t1_app_last", m0.tlast,  64'(i == 7));
      chk("t1_app_srdy", s0.tready, 0);
      step();
    end
    #1;
    chk("t1_idle_vld", m0.tvalid, 0);

    // Single-byte frame, stall pattern 1,0,0,1 during append, next frame queued upstream
    @(negedge clk);
    s0.tvalid = 1'b1; s0.tdata = 8'h5A; s0.tlast = 1'b1;
    rtc = 64'h1122334455667788;
    #1;
    chk("st_b0_data", m0.tdata, 8'h5A);
    chk("st_b0_last", m0.tlast, 0);
    step();
    s0.tdata = 8'h77;
    rtc = 64'h0000_0000_0000_0042;
    sb = 64'h1122334455667788;
    rdy_pat = 4'b1001;
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      m0.tready = rdy_pat[cyc % 4];
      #1;
      chk("st_vld",  m0.tvalid, 1);
      chk("st_data", m0.tdata,  64'(sb[63 - 8*k -: 8]));
      chk("st_last", m0.tlast,  64'(k == 7));
      chk("st_srdy", s0.tready, 0);
      if (m0.tready) k++;
      cyc++;
      step();
    end
    chk("st_byte_count", 64'(k), 8);
    m0.tready = 1'b1;
    #1;
    chk("b2b_srdy", s0.tready, 1);
    chk("b2b_data", m0.tdata,  8'h77);
    chk("b2b_vld",  m0.tvalid, 1);
    chk("b2b_last", m0.tlast,  0);
    step();
    s0.tvalid = 1'b0; s0.tlast = 1'b0;
    #1;
    chk("b2b_ts_valid", tv0, 1);
    chk("b2b_ts_out",   ts0, 64'h42);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_app_data", m0.tdata, (i == 7) ? 64'h42 : 64'h0);
      chk("b2b_app_last", m0.tlast, 64'(i == 7));
      step();
      #1;
    end
    chk("b2b_idle_vld", m0.tvalid, 0);

    // 32-bit stamp with CORR=5 wrapping past 2^32
    @(negedge clk);
    s1.tvalid = 1'b1; s1.tdata = 8'hAA; s1.tlast = 1'b1;
    rtc = 64'hDEAD_BEEF_FFFF_FFFE;
    #1;
    chk("wr_b0_data", m1.tdata, 8'hAA);
    chk("wr_b0_last", m1.tlast, 0);
    step();
    s1.tvalid = 1'b0; s1.tlast = 1'b0;
    e1 = '{8'h00, 8'h00, 8'h00, 8'h03};
    #1;
    chk("wr_ts_valid", tv1, 1);
    chk("wr_ts_out",   ts1, 32'h0000_0003);
    for (int i = 0; i < 4; i++) begin
      chk("wr_app_data", m1.tdata, e1[i]);
      chk("wr_app_last", m1.tlast, 64'(i == 3));
      step();
      #1;
    end
    chk("wr_idle_vld", m1.tvalid, 0);

    // Sideband-only mode, two back-to-back 3-byte frames
    @(negedge clk);
    fb = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    for (int i = 0; i < 6; i++) begin
      logic el;
      el = (i == 2) || (i == 5);
      s2.tvalid = 1'b1; s2.tdata = fb[i]; s2.tlast = el;
      rtc = (i == 0) ? 64'hABCD_1234_5678_9ABC :
            (i == 3) ? 64'hFFFF_8000_0000_0001 : 64'h5555_5555_5555_5555;
      #1;
      chk("sb_data", m2.tdata,  fb[i]);
      chk("sb_last", m2.tlast,  el);
      chk("sb_vld",  m2.tvalid, 1);
      chk("sb_srdy", s2.tready, 1);
      chk("sb_ts_valid", tv2, 64'((i == 1) || (i == 4)));
      chk("sb_ts_out", ts2, (i == 0) ? 64'h0 :
                            (i <= 3) ? 64'h1234_5678_9ABC : 64'h8000_0000_0001);
      step();
    end
    s2.tvalid = 1'b0; s2.tlast = 1'b0;
    #1;
    chk("sb_end_ts_valid", tv2, 0);
    chk("sb_end_ts_out",   ts2, 64'h8000_0000_0001);

    // Reset asserted while idx=3 of the appended stamp
    @(negedge clk);
    s0.tvalid = 1'b1; s0.tdata = 8'hC3; s0.tlast = 1'b1;
    rtc = 64'h0A0B0C0D0E0F1011;
    step();
    s0.tvalid = 1'b0; s0.tlast = 1'b0;
    step();
    step();
    step();
    step();
    #1;
    chk("rm_pre_data", m0.tdata,  8'h0E);
    chk("rm_pre_vld",  m0.tvalid, 1);
    rst_n = 1'b0;
    s0.tvalid = 1'b1; s0.tdata = 8'h66;
    #1;
    chk("rm_vld",    m0.tvalid, 0);
    chk("rm_last",   m0.tlast,  0);
    chk("rm_srdy",   s0.tready, 0);
    chk("rm_ts_out", ts0, 0);
    s0.tvalid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    s0.tvalid = 1'b1; s0.tdata = 8'hD4; s0.tlast = 1'b1;
    rtc = 64'h0000_0000_0000_00FF;
    #1;
    chk("rm_nx_data", m0.tdata,  8'hD4);
    chk("rm_nx_vld",  m0.tvalid, 1);
    chk("rm_nx_last", m0.tlast,  0);
    step();
    s0.tvalid = 1'b0; s0.tlast = 1'b0;
    #1;
    chk("rm_nx_ts_valid", tv0, 1);
    chk("rm_nx_ts_out",   ts0, 64'hFF);
    for (int i = 0; i < 8; i++) begin
      chk("rm_app_data", m0.tdata, (i == 7) ? 64'hFF : 64'h0);
      chk("rm_app_last", m0.tlast, 64'(i == 7));
      step();
      #1;
    end
    chk("rm_idle_vld", m0.tvalid, 0);

`ifdef TSU_FRAME_CNT_EN
    // Frame counter saturation from a preloaded value
    @(negedge clk);
    force u2.r_frame_cnt = 32'hFFFF_FFFE;
    step();
    release u2.r_frame_cnt;
    for (int i = 0; i < 3; i++) begin
      s2.tvalid = 1'b1; s2.tdata = 8'(i); s2.tlast = 1'b1;
      step();
    end
    s2.tvalid = 1'b0; s2.tlast = 1'b0;
    #1;
    chk("fc_saturate", fc2, 32'hFFFF_FFFF);
    step();
    #1;
    chk("fc_hold", fc2, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
